broadcast_scheduler: RTL and testbench
======================================

# broadcast_scheduler

Round-robin scheduler that shares the single scalar-to-16-lane broadcast path between up to NUM_REQ requesters, such as the weight buffer, activation buffer, bias loader and config/scalar port. A requester posts a burst descriptor (word count and destination lane mask). The scheduler grants one requester at a time, holds the grant for the whole burst, and muxes that requester's word stream onto the broadcast path with lane mask, source ID and last-word tagging. It sits between the on-chip buffers and the broadcast datapath that fans words out to the PE columns.

## Interface
- DATA_WIDTH, 32, width of one broadcast word
- NUM_REQ, 4, number of requesters (2..8)
- LEN_WIDTH, 8, burst length field width; encodes words-1
- LANES, 16, destination lane count (mask width)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester burst request; held until req_ready
- req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst length minus one; slice i at [i*LEN_WIDTH +: LEN_WIDTH]
- req_mask  in  NUM_REQ*LANES  per-requester destination lane mask
- req_ready  out  NUM_REQ  one-hot, one-cycle descriptor-accept pulse
- src_data  in  NUM_REQ*DATA_WIDTH  per-requester word stream
- src_valid  in  NUM_REQ  per-requester word valid
- src_ready  out  NUM_REQ  per-requester word ready; only granted bit can be 1
- bc_data  out  DATA_WIDTH  word to broadcast path
- bc_valid  out  1  word valid to broadcast path
- bc_ready  in  1  broadcast path ready
- bc_lane_mask  out  LANES  lane mask of current burst
- bc_src_id  out  clog2(NUM_REQ)  granted requester index
- bc_last  out  1  current word is final word of burst
- busy  out  1  burst in progress

## Operation
- States: IDLE, STREAM. Reset enters IDLE.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge, latch grant_id, remaining = req_len[grant], bc_lane_mask = req_mask[grant]; pulse req_ready[grant]; enter STREAM.
  - If no requests, stay in IDLE.
- STREAM:
  - bc_data = src_data[grant_id]; bc_valid = src_valid[grant_id]; src_ready[grant_id] = bc_ready. These are combinational from registered grant_id.
  - A word transfers when bc_valid and bc_ready are both high.
  - bc_last = (remaining == 0).
  - Each transfer decrements remaining.
  - A transfer with bc_last high ends the burst: return to IDLE, set rr_ptr = grant_id+1 (wrap to 0 at NUM_REQ).
- Ungranted requesters see src_ready = 0. Their req_valid and src_valid are ignored, and they may change freely.
- The grant is non-preemptive. A stalled source (src_valid low) or a stalled sink (bc_ready low) holds the grant indefinitely.
- req_len, req_mask and req_valid for the granted requester are sampled only at the grant edge. Changes after req_ready have no effect.
- Burst length is req_len+1 words: 1..2^LEN_WIDTH (256 at default).
- The remaining counter is LEN_WIDTH bits and is never decremented past 0.
- bc_lane_mask of all zeros is legal and is passed through unchanged; the broadcast path discards such words.
- busy = (state == STREAM).

## Timing
- Reset values: req_ready=0, src_ready=0, bc_valid=0, bc_data=0, bc_last=0, bc_lane_mask=0, bc_src_id=0, busy=0, rr_ptr=0, remaining=0.
- While not in STREAM, bc_valid and src_ready are forced to 0. bc_data is driven to 0 outside STREAM.
- Grant latency: req_valid high in IDLE during cycle t gives req_ready, busy and STREAM in cycle t+1. The first word can transfer in cycle t+1.
- Data path: zero added latency; word accepted in cycle k appears on bc_data in cycle k.
- Burst end: last transfer in cycle k means IDLE in k+1, with busy=0 and arbitration in k+1. The next grant takes effect in k+2.
- Minimum gap between bursts is one idle cycle.
- Simultaneous requests are resolved by rr_ptr only; no fixed priority.
- A requester that drops req_valid before being granted is not granted and not remembered.
- Reset asserted mid-burst aborts immediately: all outputs return to reset values on the next edge and rr_ptr returns to 0. The partial burst is not completed or reported.

## Test plan
- Single burst: req 2 with len=3 and mask=16'h00FF; source always valid; bc_ready=1. Expect req_ready=4'b0100 for one cycle, then 4 words, bc_src_id=2, bc_last on the 4th word only, and busy low on the following cycle.
- Round-robin fairness: all 4 requesters hold req_valid with len=0. Expect grant order 0,1,2,3,0 with one idle cycle between each grant.
- Backpressure: len=7, bc_ready toggles 1,0,1,0…, and src_valid is low in cycles 3 and 4. Expect exactly 8 transfers, no duplicates or drops, src_ready mirrors bc_ready for the granted requester only, and bc_last only on the 8th transfer.
- Max length: len=8'hFF. Expect exactly 256 transfers with bc_last only on the last.
- Isolation: req 1 is granted while req 3 toggles src_valid and req_valid. Expect src_ready[3]=0 throughout, bc_data to carry only source 1 words, and req 3 granted next.
- Reset mid-burst: rst asserted after 2 of 5 words. Expect all outputs at reset values on the next cycle. After reset, requesters 0 and 3 requesting together must grant 0 first.

Source files
------------

// File: rtl/broadcast_scheduler.sv
// Round-robin owner of the scalar-to-lane broadcast path: grants one requester per burst
// and streams its words out tagged with lane mask, source id and last-word flag.
module broadcast_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int LANES      = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*LANES-1:0]        req_mask,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   src_data,
  input  logic [NUM_REQ-1:0]              src_valid,
  output logic [NUM_REQ-1:0]              src_ready,
  output logic [DATA_WIDTH-1:0]           bc_data,
  output logic                            bc_valid,
  input  logic                            bc_ready,
  output logic [LANES-1:0]                bc_lane_mask,
  output logic [ID_W-1:0]                 bc_src_id,
  output logic                            bc_last,
  output logic                            busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LANES-1:0]       lane_mask_q, lane_mask_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W:0]          cand;
  logic                   in_stream;
  logic                   xfer;

  // Upward search from rr_ptr, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    in_stream = (state_q == STREAM);
    bc_valid  = in_stream & src_valid[grant_id_q];
    xfer      = bc_valid & bc_ready;
    bc_last   = in_stream & (remaining_q == '0);
    bc_data   = '0;
    src_ready = '0;
    if (in_stream) begin
      bc_data               = src_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      src_ready[grant_id_q] = bc_ready;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    lane_mask_d = lane_mask_q;
    req_ready_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d              = STREAM;
          grant_id_d           = pick_id;
          remaining_d          = req_len[int'(pick_id)*LEN_WIDTH +: LEN_WIDTH];
          lane_mask_d          = req_mask[int'(pick_id)*LANES +: LANES];
          req_ready_d[pick_id] = 1'b1;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (remaining_q == '0) begin
            state_d  = IDLE;
            rr_ptr_d = (int'(grant_id_q) == NUM_REQ-1) ? '0 : grant_id_q + ID_W'(1);
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      lane_mask_q <= '0;
      req_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      lane_mask_q <= lane_mask_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign bc_lane_mask = lane_mask_q;
  assign bc_src_id    = grant_id_q;
  assign busy         = in_stream;

endmodule

// File: tb/tb_broadcast_scheduler.sv
// Randomized scoreboard bench for broadcast_scheduler against a burst-level arbitration model.
module tb_broadcast_scheduler;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int LW = 8;
  localparam int LN = 16;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR*LW-1:0]     req_len;
  logic [NR*LN-1:0]     req_mask;
  logic [NR-1:0]        req_ready;
  logic [NR*DW-1:0]     src_data;
  logic [NR-1:0]        src_valid;
  logic [NR-1:0]        src_ready;
  logic [DW-1:0]        bc_data;
  logic                 bc_valid;
  logic                 bc_ready;
  logic [LN-1:0]        bc_lane_mask;
  logic [IW-1:0]        bc_src_id;
  logic                 bc_last;
  logic                 busy;

  broadcast_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_WIDTH(LW), .LANES(LN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_len(req_len), .req_mask(req_mask), .req_ready(req_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .bc_data(bc_data), .bc_valid(bc_valid), .bc_ready(bc_ready),
    .bc_lane_mask(bc_lane_mask), .bc_src_id(bc_src_id), .bc_last(bc_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [LN-1:0] mask; } grant_t;
  typedef struct { logic [DW-1:0] data; bit last; int id; logic [LN-1:0] mask; } word_t;
  typedef struct { bit zero; bit busy; bit bcv; logic [NR-1:0] srdy; } stat_t;

  grant_t gq[$];
  word_t  wq[$];
  stat_t  sq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the path, how many words remain, where the pointer sits.
  bit            m_busy, m_zero;
  int            m_gid, m_rem, m_rr, m_cyc, m_words;
  logic [LN-1:0] m_mask;
  bit            pend[NR];
  int            p_len[NR];
  logic [LN-1:0] p_mask[NR];

  int bc_mode, sv_mode, auto_req, max_len;
  bit bc_tog, mon_en;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic post(int i, int len, logic [LN-1:0] mask);
    pend[i] = 1'b1; p_len[i] = len; p_mask[i] = mask;
  endtask

  task automatic cycle(bit do_rst);
    stat_t  st;
    word_t  w;
    grant_t g;
    int     c;
    rst = do_rst;
    for (int i = 0; i < NR; i++) begin
      if (auto_req != 0 && !pend[i] && $urandom_range(0, 99) < auto_req) begin
        pend[i]   = 1'b1;
        p_len[i]  = $urandom_range(0, max_len);
        p_mask[i] = ($urandom_range(0, 7) == 0) ? '0 : LN'($urandom);
      end else if (auto_req != 0 && sv_mode == 2 && pend[i] && $urandom_range(0, 29) == 0) begin
        pend[i] = 1'b0;
      end
      req_valid[i]        = pend[i];
      req_len[i*LW +: LW] = pend[i] ? LW'(p_len[i]) : LW'($urandom);
      req_mask[i*LN +: LN] = pend[i] ? p_mask[i] : LN'($urandom);
      src_data[i*DW +: DW] = $urandom;
      src_valid[i]        = (sv_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    if (sv_mode == 3 && m_busy && (m_cyc == 2 || m_cyc == 3)) src_valid[m_gid] = 1'b0;
    case (bc_mode)
      0: bc_ready = 1'b1;
      1: begin bc_ready = bc_tog; bc_tog = ~bc_tog; end
      default: bc_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (do_rst) bc_ready = 1'b0;

    st.zero = m_zero;
    st.busy = m_busy;
    st.bcv  = m_busy && src_valid[m_gid];
    st.srdy = '0;
    if (m_busy) st.srdy[m_gid] = bc_ready;
    sq.push_back(st);

    m_zero = 1'b0;
    if (do_rst) begin
      m_busy = 1'b0; m_rr = 0; m_rem = 0; m_zero = 1'b1;
    end else if (m_busy) begin
      m_cyc++;
      if (src_valid[m_gid] && bc_ready) begin
        w.data = src_data[m_gid*DW +: DW];
        w.last = (m_rem == 0);
        w.id   = m_gid;
        w.mask = m_mask;
        wq.push_back(w);
        m_words++;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_rr   = (m_gid + 1) % NR;
        end else begin
          m_rem--;
        end
      end
    end else begin
      for (int k = 0; k < NR; k++) begin
        c = (m_rr + k) % NR;
        if (req_valid[c]) begin
          m_busy = 1'b1; m_gid = c; m_rem = p_len[c]; m_mask = p_mask[c];
          m_cyc = 0; m_words = 0; pend[c] = 1'b0;
          g.id = c; g.mask = p_mask[c];
          gq.push_back(g);
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NR; i++) r |= pend[i];
    return r;
  endfunction

  task automatic drain(string name, int budget);
    int n = 0;
    while ((m_busy || any_pend()) && n < budget) begin
      cycle(1'b0);
      n++;
    end
    if (m_busy || any_pend()) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=%0d cycles required<%0d", name, n, budget);
    end
  endtask

  // Monitor: pops per-cycle status every cycle, grants on req_ready, words on each transfer.
  initial begin
    stat_t  st;
    grant_t g;
    word_t  w;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (sq.size() != 0) begin
        st = sq.pop_front();
        if (st.zero) begin
          chk("reset_ctrl", {req_ready, src_ready, bc_valid, bc_last, busy, bc_src_id, bc_lane_mask}, 0);
          chk("reset_bc_data", bc_data, 0);
        end
        chk("busy", busy, st.busy);
        chk("bc_valid", bc_valid, st.bcv);
        chk("src_ready", src_ready, st.srdy);
        if (!st.busy) chk("idle_data_last", {bc_data, bc_last}, 0);
      end
      if (req_ready != '0) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual=%0h required=none", req_ready);
        end else begin
          g = gq.pop_front();
          chk("grant_onehot", req_ready, NR'(1) << g.id);
          chk("grant_src_id", bc_src_id, g.id);
          chk("grant_mask", bc_lane_mask, g.mask);
        end
      end
      if (bc_valid && bc_ready) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required=none", bc_data);
        end else begin
          w = wq.pop_front();
          chk("word_data", bc_data, w.data);
          chk("word_last", bc_last, w.last);
          chk("word_src_id", bc_src_id, w.id);
          chk("word_mask", bc_lane_mask, w.mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_len = '0; req_mask = '0;
    src_data = '0; src_valid = '0; bc_ready = 1'b0;
    m_busy = 1'b0; m_zero = 1'b1; m_rr = 0; m_rem = 0; m_gid = 0; m_cyc = 0; m_words = 0; m_mask = '0;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; p_len[i] = 0; p_mask[i] = '0; end
    bc_mode = 0; sv_mode = 0; auto_req = 0; max_len = 0; bc_tog = 1'b1; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Fairness: everyone asks for single-word bursts continuously.
    auto_req = 100; max_len = 0;
    for (int i = 0; i < NR; i++) post(i, 0, LN'(16'h1111 << i));
    repeat (12) cycle(1'b0);
    auto_req = 0;
    drain("fairness", 100);

    post(2, 3, 16'h00FF);
    drain("single_burst", 50);

    bc_mode = 1; sv_mode = 3;
    post(1, 7, 16'hF0F0);
    drain("backpressure", 100);

    bc_mode = 0; sv_mode = 0;
    post(0, 255, 16'hA5A5);
    drain("max_length", 400);

    // Isolation: requester 3 flaps while 1 owns the path, then asks for real.
    bc_mode = 2; sv_mode = 2;
    post(1, 6, 16'h0000);
    for (int n = 0; n < 6; n++) begin
      pend[3] = ~pend[3]; p_len[3] = 1; p_mask[3] = 16'h8001;
      cycle(1'b0);
    end
    post(3, 2, 16'h8001);
    drain("isolation", 300);

    auto_req = 20; max_len = 9;
    repeat (1500) cycle(1'b0);
    auto_req = 0;
    drain("random", 3000);

    // Reset two words into a five-word burst, then a tie between 0 and 3.
    bc_mode = 0; sv_mode = 0;
    post(2, 4, 16'h3C3C);
    for (int n = 0; n < 20 && !(m_busy && m_words == 2); n++) cycle(1'b0);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    cycle(1'b1);
    post(0, 1, 16'h0F0F);
    post(3, 1, 16'hF00F);
    drain("post_reset", 50);
    repeat (3) cycle(1'b0);

    @(negedge clk);
    #1;
    chk("grants_left", gq.size(), 0);
    chk("words_left", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
